mmio_bus_ctrl: RTL and testbench

Parametrised memory-mapped I/O interconnect between the processor data port and NUM_SLV peripherals (data memory, factorial unit, GPIO, FP multiplier, future accelerators). Decodes the address against per-slot base/mask pairs and runs a request/acknowledge transaction with each slave, so multi-cycle peripherals are supported. Routes read data back through a registered mux. Unmapped accesses and slave timeouts are reported as bus errors.

---
 rtl/mmio_bus_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: address-decoding request/acknowledge interconnect between the
// processor data port and NUM_SLV memory-mapped slaves, with bus-error reporting
// for unmapped accesses and slave timeouts.
module mmio_bus_ctrl #(
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter logic [NUM_SLV*AW-1:0] BASE = {32'h0000_0A00, 32'h0000_0900,
                                             32'h0000_0800, 32'h0000_0000},
    parameter logic [NUM_SLV*AW-1:0] MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                             32'hFFFF_FFF0, 32'hFFFF_FF00},
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [AW-1:0]         cpu_addr,
    input  logic [DW-1:0]         cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_err,
    output logic [DW-1:0]         cpu_rdata,
    output logic [NUM_SLV-1:0]    slv_sel,
    output logic [NUM_SLV-1:0]    slv_we,
    output logic [AW-1:0]         slv_addr,
    output logic [DW-1:0]         slv_wdata,
    input  logic [NUM_SLV-1:0]    slv_ack,
    input  logic [NUM_SLV*DW-1:0] slv_rdata,
    output logic [1:0]            err_cause,
    output logic [AW-1:0]         err_addr
);

    localparam int unsigned IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic                hit_any;
    logic [IW-1:0]       hit_idx;

    logic [AW-1:0]       addr_q;
    logic [DW-1:0]       wdata_q;
    logic                we_q;
    logic [IW-1:0]       idx_q;
    logic [CW-1:0]       cnt_q;
    logic [DW-1:0]       rdata_q;
    logic [1:0]          cause_q;
    logic [AW-1:0]       eaddr_q;

    logic                ack_sel;
    logic [DW-1:0]       rdata_sel;
    logic [NUM_SLV-1:0]  onehot;
    logic                timeout_hit;

    // Address decode: first (lowest-index) matching slot wins.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            if (!hit_any && ((cpu_addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW])) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Per-slot view of the latched target: its ack, read data and select bit.
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        onehot    = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            if (idx_q == IW'(i)) begin
                ack_sel   = slv_ack[i];
                rdata_sel = slv_rdata[i*DW +: DW];
                onehot[i] = 1'b1;
            end
        end
    end

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the completion cycle also accepts a new request so
    // back-to-back accesses lose no cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (cpu_req) begin
                    state_d = hit_any ? BUSY : ERR;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (ack_sel) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state and the latched transaction.
    always_comb begin
        cpu_ready = 1'b0;
        cpu_err   = 1'b0;
        slv_sel   = '0;
        slv_we    = '0;
        case (state_q)
            BUSY: begin
                slv_sel = onehot;
                slv_we  = we_q ? onehot : '0;
            end
            DONE: begin
                cpu_ready = 1'b1;
            end
            ERR: begin
                cpu_ready = 1'b1;
                cpu_err   = 1'b1;
            end
            default: ;
        endcase
    end

    // Transaction latch, timeout counter, read-data capture and sticky error log.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            cause_q <= '0;
            eaddr_q <= '0;
        end else if (state_q != BUSY) begin
            if (cpu_req) begin
                if (hit_any) begin
                    addr_q  <= cpu_addr;
                    wdata_q <= cpu_wdata;
                    we_q    <= cpu_we;
                    idx_q   <= hit_idx;
                    cnt_q   <= '0;
                end else begin
                    cause_q <= CAUSE_UNMAPPED;
                    eaddr_q <= cpu_addr;
                    rdata_q <= '0;
                end
            end
        end else begin
            if (ack_sel) begin
                rdata_q <= we_q ? '0 : rdata_sel;
            end else if (timeout_hit) begin
                cause_q <= CAUSE_TIMEOUT;
                eaddr_q <= addr_q;
                rdata_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign cpu_rdata = rdata_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;
    assign err_cause = cause_q;
    assign err_addr  = eaddr_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Bench for mmio_bus_ctrl: directed transactions drive a cycle-timeline model
// whose expected outputs are compared against the DUT every cycle.
module tb_mmio_bus_ctrl;

    localparam int NS = 4;
    localparam int TO = 16;

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_ready;
    logic          cpu_err;
    logic [31:0]   cpu_rdata;
    logic [3:0]    slv_sel;
    logic [3:0]    slv_we;
    logic [31:0]   slv_addr;
    logic [31:0]   slv_wdata;
    logic [3:0]    slv_ack;
    logic [127:0]  slv_rdata;
    logic [1:0]    err_cause;
    logic [31:0]   err_addr;

    mmio_bus_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .slv_sel   (slv_sel),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_ack   (slv_ack),
        .slv_rdata (slv_rdata),
        .err_cause (err_cause),
        .err_addr  (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory map as the system sees it.
    logic [31:0] m_base [NS] = '{32'h0000_0000, 32'h0000_0800, 32'h0000_0900, 32'h0000_0A00};
    logic [31:0] m_mask [NS] = '{32'hFFFF_FF00, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};

    // Expected DUT outputs for the current cycle.
    logic        exp_ready, exp_err;
    logic [31:0] exp_rdata, exp_saddr, exp_swdata, exp_eaddr;
    logic [3:0]  exp_sel, exp_we;
    logic [1:0]  exp_cause;
    logic        chk_on;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_slot(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & m_mask[i]) == m_base[i]) return i;
        end
        return -1;
    endfunction

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cpu_ready", 32'(cpu_ready), 32'(exp_ready));
            chk("cpu_err",   32'(cpu_err),   32'(exp_err));
            chk("cpu_rdata", cpu_rdata,      exp_rdata);
            chk("slv_sel",   32'(slv_sel),   32'(exp_sel));
            chk("slv_we",    32'(slv_we),    32'(exp_we));
            chk("slv_addr",  slv_addr,       exp_saddr);
            chk("slv_wdata", slv_wdata,      exp_swdata);
            chk("err_cause", 32'(err_cause), 32'(exp_cause));
            chk("err_addr",  err_addr,       exp_eaddr);
        end
    end

    task automatic set_slave_data(input int slot, input logic [31:0] d);
        for (int i = 0; i < NS; i++) begin
            slv_rdata[i*32 +: 32] = (i == slot) ? d : (32'hBAD0_0000 | 32'(i));
        end
    endtask

    task automatic expect_quiet();
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        exp_sel   = 4'b0000;
        exp_we    = 4'b0000;
    endtask

    // One idle cycle, optionally with acks from any slave (must be ignored).
    task automatic idle(input logic [3:0] spur);
        slv_ack = spur;
        @(posedge clk);
        #1;
        slv_ack = 4'b0000;
        expect_quiet();
    endtask

    // One transaction; ack_at is the BUSY cycle the target acks in (0 = never).
    // Returns during the ready cycle so a following call runs back-to-back.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int ack_at, input logic [3:0] spur);
        int          slot;
        int          nb;
        logic [3:0]  oh;
        slot = model_slot(addr);
        set_slave_data(slot, rd);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        @(posedge clk);
        #1;
        cpu_req   = 1'b0;
        cpu_addr  = 32'hFFFF_FFFF;
        cpu_wdata = 32'h5EED_0000 | 32'($urandom_range(0, 255));
        if (slot < 0) begin
            expect_quiet();
            exp_ready = 1'b1;
            exp_err   = 1'b1;
            exp_rdata = 32'h0;
            exp_cause = 2'b01;
            exp_eaddr = addr;
            return;
        end
        oh         = 4'(1 << slot);
        exp_saddr  = addr;
        exp_swdata = wd;
        nb = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
        for (int c = 1; c <= nb; c++) begin
            expect_quiet();
            exp_sel = oh;
            exp_we  = we ? oh : 4'b0000;
            slv_ack = spur | ((c == ack_at) ? oh : 4'b0000);
            @(posedge clk);
            #1;
            slv_ack = 4'b0000;
        end
        expect_quiet();
        exp_ready = 1'b1;
        if (ack_at >= 1 && ack_at <= TO) begin
            exp_rdata = we ? 32'h0 : rd;
        end else begin
            exp_err   = 1'b1;
            exp_rdata = 32'h0;
            exp_cause = 2'b10;
            exp_eaddr = addr;
        end
    endtask

    // Reset asserted in the 2nd BUSY cycle of a slot-1 read that is never acked.
    task automatic rst_mid();
        set_slave_data(1, 32'h7777_7777);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0804;
        @(posedge clk);
        #1;
        cpu_req   = 1'b0;
        expect_quiet();
        exp_sel   = 4'b0010;
        exp_saddr = 32'h0000_0804;
        exp_swdata = cpu_wdata;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_quiet();
        exp_rdata  = 32'h0;
        exp_saddr  = 32'h0;
        exp_swdata = 32'h0;
        exp_cause  = 2'b00;
        exp_eaddr  = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = 32'h0;
        cpu_wdata = 32'h0;
        slv_ack = 4'b0000;
        slv_rdata = '0;
        chk_on = 1'b0;
        expect_quiet();
        exp_rdata = 32'h0;
        exp_saddr = 32'h0;
        exp_swdata = 32'h0;
        exp_cause = 2'b00;
        exp_eaddr = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4'b0000);

        // Model decode pinned against the memory map by hand.
        chk("dec_0044", 32'(model_slot(32'h0000_0044)), 32'd0);
        chk("dec_0904", 32'(model_slot(32'h0000_0904)), 32'd2);
        chk("dec_0A08", 32'(model_slot(32'h0000_0A08)), 32'd3);
        chk("dec_0B00", 32'(model_slot(32'h0000_0B00)), 32'hFFFF_FFFF);

        // Read slot 0, ack in first BUSY cycle.
        txn(1'b0, 32'h0000_0044, 32'h0, 32'h1234_5678, 1, 4'b0000);
        chk("t1_ready_lit", 32'(cpu_ready), 32'd1);
        chk("t1_rdata_lit", cpu_rdata, 32'h1234_5678);
        idle(4'b0000);

        // Unmapped read.
        txn(1'b0, 32'h0000_0B00, 32'h0, 32'h0, 0, 4'b0000);
        chk("t3_err_lit",   32'(cpu_err), 32'd1);
        chk("t3_cause_lit", 32'(err_cause), 32'd1);
        chk("t3_eaddr_lit", err_addr, 32'h0000_0B00);
        idle(4'b0000);

        // Write slot 2, ack after 3 cycles.
        txn(1'b1, 32'h0000_0904, 32'hA5A5_A5A5, 32'h55AA_55AA, 3, 4'b0000);
        chk("t2_rdata_lit", cpu_rdata, 32'h0);
        idle(4'b0000);

        // Slot 3 acks exactly on the final timeout cycle: normal completion.
        txn(1'b0, 32'h0000_0A0C, 32'h0, 32'hFACE_0016, TO, 4'b0000);
        chk("t4b_err_lit", 32'(cpu_err), 32'd0);
        idle(4'b0000);

        // Slot 3 never acks: timeout.
        txn(1'b0, 32'h0000_0A08, 32'h0, 32'hCAFE_0003, 0, 4'b0000);
        chk("t4_cause_lit", 32'(err_cause), 32'd2);
        chk("t4_eaddr_lit", err_addr, 32'h0000_0A08);
        idle(4'b0000);

        // Acks in IDLE are ignored.
        idle(4'b1111);
        idle(4'b0000);

        // Spurious ack from slave 1 during a slot-0 read.
        txn(1'b0, 32'h0000_0010, 32'h0, 32'h600D_0000, 2, 4'b0010);
        idle(4'b0000);

        // Back-to-back reads: slot 1 then slot 2.
        txn(1'b0, 32'h0000_0808, 32'h0, 32'h1111_1111, 1, 4'b0000);
        txn(1'b0, 32'h0000_090C, 32'h0, 32'h2222_2222, 2, 4'b0000);
        idle(4'b0000);

        // Reset mid-transaction.
        rst_mid();
        idle(4'b0000);
        idle(4'b0000);

        @(negedge clk);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
